// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } mdu_state_e;

  localparam logic [4:0]  REG_ZERO            = 5'd0;
  localparam int unsigned MDU_LATENCY_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT       = 6;

endpackage

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer: IDLE -> BUSY (counted) -> DRAIN -> IDLE.
module mdu_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic start,
  output logic mdu_busy,
  output logic mdu_done,
  output logic not_idle
);

  // BUSY spans LATENCY-1 cycles and DRAIN the last one.
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MDU_LATENCY - 2);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBusy;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StDrain;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDrain: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_busy = busy_q;
  assign mdu_done = done_q;
  assign not_idle = (state_q != StIdle);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, branch flush, MDU hazards.
// Define STALL_STATS_EN to add saturating Stall_Count / Flush_Count outputs.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rt_EX,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        Branch_Taken_EX,
  input  logic        MDU_Start_ID,
  input  logic        HiLo_Read_ID,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        Stall,
`ifdef STALL_STATS_EN
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count,
`endif
  output logic        MDU_Busy,
  output logic        MDU_Done
);

  logic load_use;
  logic mdu_stall;
  logic stall_int;
  logic mdu_accept;
  logic not_idle;

  assign load_use  = MemRead_EX & (Rt_EX != REG_ZERO) &
                     ((Rs_ID == Rt_EX) | (Rt_ID == Rt_EX));
  assign mdu_stall = (HiLo_Read_ID | MDU_Start_ID) & not_idle;
  assign stall_int = (load_use | mdu_stall) & ~Branch_Taken_EX;
  // A squashed or stalled ID instruction must not launch the MDU.
  assign mdu_accept = MDU_Start_ID & ~stall_int & ~Branch_Taken_EX;

  mdu_sequencer #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mdu_sequencer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start    (mdu_accept),
    .mdu_busy (MDU_Busy),
    .mdu_done (MDU_Done),
    .not_idle (not_idle)
  );

  // While in reset the front end is frozen and flushed.
  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b1;
    ID_EX_Bubble = 1'b1;
    Stall        = 1'b0;
    if (Rst_n) begin
      PC_Write     = ~stall_int;
      IF_ID_Write  = ~stall_int;
      IF_ID_Flush  = Branch_Taken_EX;
      ID_EX_Bubble = stall_int | Branch_Taken_EX;
      Stall        = stall_int;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (Branch_Taken_EX && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench: one DUT with MDU_LATENCY=4, one with the 32-cycle default.
module tb_pipeline_stall_controller;

  logic       clk;
  logic       rst_n;
  logic       mem_read_ex;
  logic [4:0] rt_ex;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       branch_ex;
  logic       start_id;
  logic       hilo_id;
  logic       start32;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, stall, mdu_busy, mdu_done;
  logic pc_write32, if_id_write32, if_id_flush32, id_ex_bubble32, stall32, busy32, done32;
`ifdef STALL_STATS_EN
  logic [31:0] stall_count, flush_count, stall_count32, flush_count32;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_stall_controller #(
    .MDU_LATENCY (4),
    .CNT_W       (6)
  ) u_dut (
    .Clk             (clk),
    .Rst_n           (rst_n),
    .MemRead_EX      (mem_read_ex),
    .Rt_EX           (rt_ex),
    .Rs_ID           (rs_id),
    .Rt_ID           (rt_id),
    .Branch_Taken_EX (branch_ex),
    .MDU_Start_ID    (start_id),
    .HiLo_Read_ID    (hilo_id),
    .PC_Write        (pc_write),
    .IF_ID_Write     (if_id_write),
    .IF_ID_Flush     (if_id_flush),
    .ID_EX_Bubble    (id_ex_bubble),
    .Stall           (stall),
`ifdef STALL_STATS_EN
    .Stall_Count     (stall_count),
    .Flush_Count     (flush_count),
`endif
    .MDU_Busy        (mdu_busy),
    .MDU_Done        (mdu_done)
  );

  pipeline_stall_controller #(
    .MDU_LATENCY (32),
    .CNT_W       (6)
  ) u_dut32 (
    .Clk             (clk),
    .Rst_n           (rst_n),
    .MemRead_EX      (mem_read_ex),
    .Rt_EX           (rt_ex),
    .Rs_ID           (rs_id),
    .Rt_ID           (rt_id),
    .Branch_Taken_EX (branch_ex),
    .MDU_Start_ID    (start32),
    .HiLo_Read_ID    (1'b0),
    .PC_Write        (pc_write32),
    .IF_ID_Write     (if_id_write32),
    .IF_ID_Flush     (if_id_flush32),
    .ID_EX_Bubble    (id_ex_bubble32),
    .Stall           (stall32),
`ifdef STALL_STATS_EN
    .Stall_Count     (stall_count32),
    .Flush_Count     (flush_count32),
`endif
    .MDU_Busy        (busy32),
    .MDU_Done        (done32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_ex = 1'b0;
    rt_ex       = 5'd0;
    rs_id       = 5'd0;
    rt_id       = 5'd0;
    branch_ex   = 1'b0;
    start_id    = 1'b0;
    hilo_id     = 1'b0;
    start32     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("rst_pc_write", pc_write, 0);
    check("rst_if_id_write", if_id_write, 0);
    check("rst_flush", if_id_flush, 1);
    check("rst_bubble", id_ex_bubble, 1);
    check("rst_stall", stall, 0);
    check("rst_busy", mdu_busy, 0);
    check("rst_done", mdu_done, 0);
    #10 rst_n = 1'b1;

    cyc();
    #1;
    check("idle_pc_write", pc_write, 1);
    check("idle_stall", stall, 0);
    check("idle_bubble", id_ex_bubble, 0);
    check("idle_flush", if_id_flush, 0);

    // Load-use on rs
    cyc();
    mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; rt_id = 5'd3;
    #1;
    check("lu_stall", stall, 1);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_ex_bubble, 1);
    check("lu_flush", if_id_flush, 0);
    // Next cycle EX holds the bubble
    cyc();
    mem_read_ex = 1'b0; rt_ex = 5'd0;
    #1;
    check("lu_one_cycle", stall, 0);
    check("lu_after_pc", pc_write, 1);

    // Load-use on rt
    cyc();
    mem_read_ex = 1'b1; rt_ex = 5'd17; rs_id = 5'd2; rt_id = 5'd17;
    #1;
    check("lu_rt_stall", stall, 1);
    // No match
    cyc();
    rt_id = 5'd16;
    #1;
    check("lu_nomatch", stall, 0);
    // $0 never stalls
    cyc();
    rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    #1;
    check("lu_r0_stall", stall, 0);
    check("lu_r0_pc", pc_write, 1);

    // Branch beats load-use
    cyc();
    rt_ex = 5'd8; rs_id = 5'd8; branch_ex = 1'b1;
    #1;
    check("br_stall", stall, 0);
    check("br_pc_write", pc_write, 1);
    check("br_if_id_write", if_id_write, 1);
    check("br_flush", if_id_flush, 1);
    check("br_bubble", id_ex_bubble, 1);

    // Branch squashes an MDU start
    cyc();
    idle_inputs();
    start_id = 1'b1; branch_ex = 1'b1;
    #1;
    check("sq_stall", stall, 0);
    cyc();
    idle_inputs();
    hilo_id = 1'b1;
    #1;
    check("sq_busy", mdu_busy, 0);
    check("sq_hilo_stall", stall, 0);

    // MDU sequence, latency 4, mfhi held in ID
    cyc();
    idle_inputs();
    start_id = 1'b1;
    #1;
    check("mdu_c0_stall", stall, 0);
    check("mdu_c0_busy", mdu_busy, 0);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      start_id = 1'b0; hilo_id = 1'b1;
      #1;
      check($sformatf("mdu_c%0d_busy", c), mdu_busy, (c <= 4) ? 1 : 0);
      check($sformatf("mdu_c%0d_done", c), mdu_done, (c == 4) ? 1 : 0);
      check($sformatf("mdu_c%0d_stall", c), stall, (c <= 4) ? 1 : 0);
      check($sformatf("mdu_c%0d_pc", c), pc_write, (c <= 4) ? 0 : 1);
    end

    // Branch during BUSY does not abort the MDU
    cyc();
    idle_inputs();
    start_id = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      idle_inputs();
      branch_ex = (c == 1);
      #1;
      check($sformatf("mdubr_c%0d_busy", c), mdu_busy, (c <= 4) ? 1 : 0);
      check($sformatf("mdubr_c%0d_done", c), mdu_done, (c == 4) ? 1 : 0);
    end

    // Reset mid-BUSY on the 32-cycle instance
    cyc();
    idle_inputs();
    start32 = 1'b1;
    #1;
    cyc();
    start32 = 1'b0;
    #1;
    check("r32_c1_busy", busy32, 1);
    cyc();
    #1;
    check("r32_c2_busy", busy32, 1);
    rst_n = 1'b0;
    #1;
    check("r32_rst_busy", busy32, 0);
    check("r32_rst_done", done32, 0);
    check("r32_rst_pc", pc_write32, 0);
    check("r32_rst_if_id_write", if_id_write32, 0);
    check("r32_rst_flush", if_id_flush32, 1);
    check("r32_rst_bubble", id_ex_bubble32, 1);
    check("r32_rst_stall", stall32, 0);
    cyc();
    #1 rst_n = 1'b1;
    cyc();
    start32 = 1'b1;
    #1;
    check("r32_restart_stall", stall32, 0);
    cyc();
    start32 = 1'b0;
    #1;
    check("r32_restart_busy", busy32, 1);

`ifdef STALL_STATS_EN
    rst_n = 1'b0;
    #1;
    check("st_rst_stall_cnt", stall_count, 0);
    check("st_rst_flush_cnt", flush_count, 0);
    cyc();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle_inputs();
      mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8;
      cyc();
      idle_inputs();
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      branch_ex = 1'b1;
      cyc();
      branch_ex = 1'b0;
    end
    #1;
    check("st_stall_cnt", stall_count, 3);
    check("st_flush_cnt", flush_count, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
